histogram_control: RTL and testbench

HISTOGRAM_CONTROL -- requirements
Module: histogram_control

---
 rtl/histogram_pkg.sv | 21 ++
 rtl/histogram_wait_timer.sv | 26 ++
 rtl/histogram_control.sv | 121 ++++++++++++
 tb/tb_histogram_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram controller: FSM state encoding and
// default memory-latency / batch-size constants.
package histogram_pkg;

    localparam int unsigned DEFAULT_MEM_LATENCY      = 1;
    localparam int unsigned DEFAULT_PIXELS_PER_BATCH = 32;

    typedef enum logic [3:0] {
        IDLE,
        RD_IN,
        WAIT_IN,
        LOAD_IN,
        RD_SCR,
        WAIT_SCR,
        LOAD_SCR,
        WRITE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/histogram_wait_timer.sv
// Down-counter that times the memory read latency; expired is high once the
// loaded count has run out.
module histogram_wait_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       count,
    output logic       expired
);

    logic [3:0] remaining;

    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (count && (remaining != '0)) begin
            remaining <= remaining - 4'd1;
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/histogram_control.sv
// Sequencer for the histogram datapath: reads input-memory batches, then per
// pixel does a read-modify-write of the scratch bin memory.
module histogram_control
    import histogram_pkg::*;
#(
    parameter int unsigned MEM_LATENCY      = DEFAULT_MEM_LATENCY,
    parameter int unsigned PIXELS_PER_BATCH = DEFAULT_PIXELS_PER_BATCH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_batches,
    input  logic        all_pixel_written,
    output logic        set_read_address_input_mem,
    output logic        read_data_ready_input_mem,
    output logic        set_read_address_scratch_mem,
    output logic        read_data_ready_scratch_mem,
    output logic        set_write_address_scratch_mem,
    output logic        shift_scratch_memory_rw_address,
    output logic        busy,
    output logic        done,
    output logic [15:0] batch_count
);

    // The timer is loaded in the read state so the wait state spans MEM_LATENCY cycles.
    localparam logic [3:0] WAIT_PRELOAD = 4'(MEM_LATENCY - 1);
    localparam logic [5:0] PIXEL_LIMIT  = 6'(PIXELS_PER_BATCH);

    state_t      state;
    state_t      next_state;
    logic [15:0] batch_target;
    logic [15:0] batch_next;
    logic [5:0]  pixel_count;
    logic [5:0]  pixel_next;
    logic        batch_end;
    logic        wait_load;
    logic        wait_count;
    logic        wait_expired;

    always_comb begin
        wait_load  = (state == RD_IN) || (state == RD_SCR);
        wait_count = (state == WAIT_IN) || (state == WAIT_SCR);
    end

    histogram_wait_timer wait_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (wait_load),
        .load_value (WAIT_PRELOAD),
        .count      (wait_count),
        .expired    (wait_expired)
    );

    always_comb begin
        next_state = state;
        batch_end  = 1'b0;
        pixel_next = pixel_count + 6'd1;
        batch_next = batch_count + 16'd1;
        case (state)
            IDLE:     if (start) next_state = (num_batches == '0) ? DONE : RD_IN;
            RD_IN:    next_state = WAIT_IN;
            WAIT_IN:  if (wait_expired) next_state = LOAD_IN;
            LOAD_IN:  next_state = RD_SCR;
            RD_SCR:   next_state = WAIT_SCR;
            WAIT_SCR: if (wait_expired) next_state = LOAD_SCR;
            LOAD_SCR: next_state = WRITE;
            WRITE:    next_state = SHIFT;
            SHIFT: begin
                // SHIFT sits between WRITE and the next scratch read so a repeated bin sees its update.
                if ((pixel_next < PIXEL_LIMIT) && !all_pixel_written) begin
                    next_state = RD_SCR;
                end else begin
                    batch_end  = 1'b1;
                    next_state = (batch_next < batch_target) ? RD_IN : DONE;
                end
            end
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                           <= IDLE;
            set_read_address_input_mem      <= 1'b0;
            read_data_ready_input_mem       <= 1'b0;
            set_read_address_scratch_mem    <= 1'b0;
            read_data_ready_scratch_mem     <= 1'b0;
            set_write_address_scratch_mem   <= 1'b0;
            shift_scratch_memory_rw_address <= 1'b0;
            busy                            <= 1'b0;
            done                            <= 1'b0;
            batch_count                     <= '0;
            batch_target                    <= '0;
            pixel_count                     <= '0;
        end else begin
            state                           <= next_state;
            set_read_address_input_mem      <= (next_state == RD_IN);
            read_data_ready_input_mem       <= (next_state == LOAD_IN);
            set_read_address_scratch_mem    <= (next_state == RD_SCR);
            read_data_ready_scratch_mem     <= (next_state == LOAD_SCR);
            set_write_address_scratch_mem   <= (next_state == WRITE);
            shift_scratch_memory_rw_address <= (next_state == SHIFT);
            busy                            <= (next_state != IDLE);
            done                            <= (next_state == DONE);
            if ((state == IDLE) && start) begin
                batch_target <= num_batches;
                batch_count  <= '0;
                pixel_count  <= '0;
            end else if (state == SHIFT) begin
                if (batch_end) begin
                    batch_count <= batch_next;
                    pixel_count <= '0;
                end else begin
                    pixel_count <= pixel_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_histogram_control.sv
// Directed bench for histogram_control: a trace model predicts every output
// cycle by cycle for two latency configurations, plus literal run totals.
module tb_histogram_control;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst1 = 1'b1, rst3 = 1'b1;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic        apw1 = 1'b0, apw3 = 1'b0;
    logic [15:0] nb1 = '0, nb3 = '0;
    logic        sia1, rdi1, ssa1, rds1, swa1, shf1, busy1, done1;
    logic        sia3, rdi3, ssa3, rds3, swa3, shf3, busy3, done3;
    logic [15:0] bc1, bc3;

    histogram_control #(.MEM_LATENCY(1), .PIXELS_PER_BATCH(32)) dut1 (
        .clock(clock), .reset(rst1), .start(start1), .num_batches(nb1),
        .all_pixel_written(apw1),
        .set_read_address_input_mem(sia1), .read_data_ready_input_mem(rdi1),
        .set_read_address_scratch_mem(ssa1), .read_data_ready_scratch_mem(rds1),
        .set_write_address_scratch_mem(swa1), .shift_scratch_memory_rw_address(shf1),
        .busy(busy1), .done(done1), .batch_count(bc1)
    );

    histogram_control #(.MEM_LATENCY(3), .PIXELS_PER_BATCH(32)) dut3 (
        .clock(clock), .reset(rst3), .start(start3), .num_batches(nb3),
        .all_pixel_written(apw3),
        .set_read_address_input_mem(sia3), .read_data_ready_input_mem(rdi3),
        .set_read_address_scratch_mem(ssa3), .read_data_ready_scratch_mem(rds3),
        .set_write_address_scratch_mem(swa3), .shift_scratch_memory_rw_address(shf3),
        .busy(busy3), .done(done3), .batch_count(bc3)
    );

    // Output vector: {6 strobes in port order, busy, done, batch_count}.
    typedef logic [23:0] ov_t;

    ov_t         q1[$], q3[$], tmpq[$];
    logic [15:0] hold1 = '0, hold3 = '0;
    int          total = 0, bad = 0;
    bit          chk_on = 1'b0;
    int          sel = 0;
    int          cyc, done_cyc, done_cnt, busy_cnt, strobe_cnt;
    int          in_rd_cnt, in_ld_cnt, rds_cnt, lds_cnt, wr_cnt, shf_cnt, order_err;
    bit          wr_open;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic ov_t mk(input int code, input bit b, input bit d, input logic [15:0] bc);
        logic [5:0] s;
        s = (code == 0) ? 6'd0 : (6'b100000 >> (code - 1));
        return {s, b, d, bc};
    endfunction

    // Expected trace from the presenting cycle through DONE: per batch an
    // input read, latency, load, then per pixel read/latency/load/write/shift.
    function automatic logic [15:0] build(input int lat, input int nb, input int apw_batch,
                                          input int apw_pix, input logic [15:0] old_bc);
        logic [15:0] bc;
        int npix;
        bc = '0;
        tmpq.delete();
        tmpq.push_back(mk(0, 0, 0, old_bc));
        for (int b = 1; b <= nb; b++) begin
            npix = (b == apw_batch) ? apw_pix : 32;
            tmpq.push_back(mk(1, 1, 0, bc));
            repeat (lat) tmpq.push_back(mk(0, 1, 0, bc));
            tmpq.push_back(mk(2, 1, 0, bc));
            for (int p = 0; p < npix; p++) begin
                tmpq.push_back(mk(3, 1, 0, bc));
                repeat (lat) tmpq.push_back(mk(0, 1, 0, bc));
                tmpq.push_back(mk(4, 1, 0, bc));
                tmpq.push_back(mk(5, 1, 0, bc));
                tmpq.push_back(mk(6, 1, 0, bc));
            end
            bc++;
        end
        tmpq.push_back(mk(0, 1, 1, bc));
        return bc;
    endfunction

    ov_t a1, a3, e1, e3, act;
    always @(negedge clock) begin
        if (chk_on) begin
            a1 = {sia1, rdi1, ssa1, rds1, swa1, shf1, busy1, done1, bc1};
            a3 = {sia3, rdi3, ssa3, rds3, swa3, shf3, busy3, done3, bc3};
            if (q1.size() > 0) e1 = q1.pop_front(); else e1 = {8'd0, hold1};
            if (q3.size() > 0) e3 = q3.pop_front(); else e3 = {8'd0, hold3};
            check("outputs_lat1", {8'd0, a1}, {8'd0, e1});
            check("outputs_lat3", {8'd0, a3}, {8'd0, e3});
            act = (sel != 0) ? a3 : a1;
            if (act[23]) in_rd_cnt++;
            if (act[22]) in_ld_cnt++;
            if (act[21]) rds_cnt++;
            if (act[20]) lds_cnt++;
            if (act[19]) wr_cnt++;
            if (act[18]) shf_cnt++;
            if (act[23:18] != 6'd0) strobe_cnt++;
            if (act[21] && wr_open) order_err++;
            if (act[19]) wr_open = 1'b1;
            if (act[18]) wr_open = 1'b0;
            if (act[17]) busy_cnt++;
            if (act[16]) begin
                done_cnt++;
                done_cyc = cyc;
            end
            cyc++;
        end
    end

    // Called in the presenting cycle; cycle k below is the k-th cycle after acceptance.
    task automatic go(input int d, input int nb, input int apw_batch, input int apw_pix,
                      input int apw_at, input int noise_at, input int rst_at, input bit hold_start);
        int  last, endk;
        ov_t keep;
        sel = d;
        cyc = 0; done_cyc = -1; done_cnt = 0; busy_cnt = 0; strobe_cnt = 0;
        in_rd_cnt = 0; in_ld_cnt = 0; rds_cnt = 0; lds_cnt = 0; wr_cnt = 0; shf_cnt = 0;
        order_err = 0; wr_open = 1'b0;
        if (d != 0) begin
            nb3 = 16'(nb); start3 = 1'b1;
            hold3 = build(3, nb, apw_batch, apw_pix, hold3);
            foreach (tmpq[i]) q3.push_back(tmpq[i]);
        end else begin
            nb1 = 16'(nb); start1 = 1'b1;
            hold1 = build(1, nb, apw_batch, apw_pix, hold1);
            foreach (tmpq[i]) q1.push_back(tmpq[i]);
        end
        last = tmpq.size() - 1;
        endk = (rst_at > 0) ? rst_at + 3 : last + 3;
        for (int k = 1; k <= endk; k++) begin
            tick();
            if (d != 0) begin
                start3 = hold_start && (k <= last);
                apw3   = (k == apw_at) || (k == noise_at);
            end else begin
                start1 = hold_start && (k <= last);
                apw1   = (k == apw_at) || (k == noise_at);
                if (k == rst_at) begin
                    rst1 = 1'b1;
                    keep = q1.pop_front();
                    q1.delete();
                    q1.push_back(keep);
                    hold1 = '0;
                end else begin
                    rst1 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        check("reset_busy", {31'd0, busy1}, 32'd0);
        check("reset_done", {31'd0, done3}, 32'd0);
        check("reset_batch_count", {16'd0, bc3}, 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        tick();

        // One batch, latency 1.
        go(0, 1, 0, 0, 0, 0, 0, 0);
        check("s1_input_addr", in_rd_cnt, 1);
        check("s1_input_load", in_ld_cnt, 1);
        check("s1_scratch_rd", rds_cnt, 32);
        check("s1_scratch_ld", lds_cnt, 32);
        check("s1_write", wr_cnt, 32);
        check("s1_shift", shf_cnt, 32);
        check("s1_done_cycle", done_cyc, 164);
        check("s1_batch_count", {16'd0, bc1}, 32'd1);

        // Three batches, latency 3.
        go(1, 3, 0, 0, 0, 0, 0, 0);
        check("s2_write", wr_cnt, 96);
        check("s2_input_addr", in_rd_cnt, 3);
        check("s2_order", order_err, 0);
        check("s2_done_cycle", done_cyc, 688);
        check("s2_batch_count", {16'd0, bc3}, 32'd3);

        // Zero batches: DONE follows the accepting edge directly.
        go(0, 0, 0, 0, 0, 0, 0, 0);
        check("s3_done_cycle", done_cyc, 1);
        check("s3_strobes", strobe_cnt, 0);
        check("s3_busy_cycles", busy_cnt, 1);
        check("s3_batch_count", {16'd0, bc1}, 32'd0);

        // Saturation in the 10th SHIFT of batch 1 (cycle 53); a pulse in cycle 20 is not a SHIFT.
        go(0, 2, 1, 10, 53, 20, 0, 0);
        check("s4_write", wr_cnt, 42);
        check("s4_done_cycle", done_cyc, 217);
        check("s4_batch_count", {16'd0, bc1}, 32'd2);

        // Reset in cycle 50 of a run, then a normal run.
        go(0, 2, 0, 0, 0, 0, 50, 0);
        check("s5_no_done", done_cnt, 0);
        check("s5_batch_count", {16'd0, bc1}, 32'd0);
        go(0, 1, 0, 0, 0, 0, 0, 0);
        check("s5_rerun_done_cycle", done_cyc, 164);
        check("s5_rerun_done_count", done_cnt, 1);

        // start held high through the whole run, including the DONE cycle.
        go(0, 1, 0, 0, 0, 0, 0, 1);
        check("s6_done_count", done_cnt, 1);
        check("s6_write", wr_cnt, 32);
        check("s6_input_addr", in_rd_cnt, 1);
        check("s6_done_cycle", done_cyc, 164);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
